grid_frame_renderer: RTL and testbench
======================================

Name: grid_frame_renderer

Overview:
- Parametrised successor to the snake-game image generator.
- Scans a GRID_W x GRID_H cell grid and reads each cell's object code from the game logic.
- Compares each code against an internal shadow copy of the last drawn frame. Only changed cells are redrawn, as CELL_PX x CELL_PX RGB565 squares.
- Drives the 8080-style 8-bit LCD bus (dcx/wr/D) with programmable write-strobe timing. Sits between the game-state logic and the LCD pins.

Parameters:
- GRID_W, 16, cells per row.
- GRID_H, 16, cells per column.
- CELL_PX, 8, pixel edge length of one cell (>=1).
- X_OFFSET, 0, screen column of cell (0,0).
- Y_OFFSET, 0, screen page of cell (0,0).
- WR_CYCLES, 1, clocks wr is held low and clocks wr is held high per byte (>=1).

Ports:
- clk  input  1  system clock
- nrst  input  1  synchronous active-low reset
- start  input  1  begin a frame scan; sampled only in IDLE
- full_redraw  input  1  sampled with start; forces every cell to be drawn
- obj_code  input  3  object code of cell at (x,y): 0 bg, 1 body, 2 head, 3 apple, 4 border, 5-7 reserved
- x  output  $clog2(GRID_W)  cell column being looked up
- y  output  $clog2(GRID_H)  cell row being looked up
- busy  output  1  high from accepted start until frame_done cycle inclusive
- frame_done  output  1  one-cycle pulse at end of scan
- dcx  output  1  0 = command byte, 1 = data byte
- wr  output  1  write strobe; LCD latches D/dcx on rising edge
- D  output  8  bus byte

Behaviour:
- Clocking and reset: one clock (clk). Reset (nrst) is synchronous and active-low.
- Reset values: wr=1, dcx=1, D=0x00, x=0, y=0, busy=0, frame_done=0, state IDLE. Shadow-valid flag cleared.
- Reset mid-operation aborts immediately, with no completion of a partial byte. The shadow cells already committed keep their contents but are ignored, because the valid flag is cleared.
- FSM states:
  - IDLE -> LOOKUP on start. Latch full_redraw | !valid as force; x=y=0; busy=1.
  - LOOKUP: x,y stable. Go to COMPARE.
  - COMPARE: sample obj_code. If force or obj_code != shadow[y][x] -> SEND, else NEXT.
  - SEND: emit the cell byte sequence. After the last byte, write obj_code into shadow[y][x], then go to NEXT.
  - NEXT: advance raster order, x inner and y outer. After (GRID_W-1, GRID_H-1) -> DONE, else LOOKUP.
  - DONE: frame_done=1 for one cycle; set valid=1; clear busy; go to IDLE.
- NEXT shares a cycle with the following LOOKUP (x,y update on the COMPARE->NEXT edge). A clean cell therefore costs exactly 2 cycles.
- obj_code held in a register from COMPARE through SEND; x,y held constant during SEND.
- start while busy is ignored. full_redraw is ignored outside the start cycle.
- Cell byte sequence, 11 + 2*CELL_PX^2 bytes:
  - 0x2A (dcx=0), then XS[15:8], XS[7:0], XE[15:8], XE[7:0] (dcx=1).
  - 0x2B (dcx=0), then YS hi/lo, YE hi/lo (dcx=1).
  - 0x2C (dcx=0).
  - CELL_PX^2 pixels, each colour[15:8] then colour[7:0] (dcx=1).
- Coordinates: XS = X_OFFSET + x*CELL_PX and XE = XS + CELL_PX - 1; YS/YE likewise with y and Y_OFFSET. All are 16-bit, truncated.
- Palette:
  - 0 -> 0x0000
  - 1 -> 0x07E0
  - 2 -> 0xFFE0
  - 3 -> 0xF800
  - 4 -> 0xFFFF
  - 5-7 -> 0x001F
- Byte timing: D and dcx change only on the cycle wr falls, and stay stable for the full byte. wr=0 for WR_CYCLES clocks, then wr=1 for WR_CYCLES clocks, so 2*WR_CYCLES clocks per byte with no gap between bytes of a cell. wr=1 outside SEND.
- Pixel counter width: $clog2(CELL_PX*CELL_PX+1). No wrap within a cell.
- Shadow: GRID_W*GRID_H x 3 flops. Written only on completion of a cell; never written in IDLE.

Test Plan:
- Reset: assert nrst=0 for one edge mid-SEND -> next cycle wr=1, dcx=1, D=0, busy=0, x=y=0. A following start redraws all 256 cells.
- First frame after reset: all obj_code=0, start -> 256*(11+128)=35584 wr rising edges, each pixel byte 0x00. frame_done pulses once; busy drops the same cycle.
- Clean frame: repeat with identical codes, start -> zero wr falling edges; frame_done high exactly 2*256+1 = 513 cycles after the start edge.
- Single change at (3,2)=1, default params -> exactly one cell sent. Bytes are 2A 00 18 00 1F | 2B 00 10 00 17 | 2C, with dcx=0 on 2A/2B/2C, then 64 x (07, E0).
- WR_CYCLES=3: wr low 3 clocks and high 3 clocks per byte; D and dcx constant across each 6-clock window. start pulsed while busy -> no second frame_done.
- full_redraw=1 with unchanged codes -> all 256 cells re-sent. Then a plain start -> no bytes sent.

Source files
------------

// File: rtl/grid_frame_renderer.sv
// Incremental grid renderer: redraws only the cells whose object code changed since
// the last drawn frame, as RGB565 squares over an 8080-style 8-bit LCD write bus.
module grid_frame_renderer #(
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 16,
  parameter int unsigned CELL_PX   = 8,
  parameter int unsigned X_OFFSET  = 0,
  parameter int unsigned Y_OFFSET  = 0,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      start,
  input  logic                      full_redraw,
  input  logic [2:0]                obj_code,
  output logic [$clog2(GRID_W)-1:0] x,
  output logic [$clog2(GRID_H)-1:0] y,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      dcx,
  output logic                      wr,
  output logic [7:0]                D
);

  localparam int unsigned XW      = $clog2(GRID_W);
  localparam int unsigned YW      = $clog2(GRID_H);
  localparam int unsigned CELLS   = GRID_W * GRID_H;
  localparam int unsigned IDX_W   = $clog2(CELLS);
  localparam int unsigned NPIX    = CELL_PX * CELL_PX;
  localparam int unsigned PW      = $clog2(NPIX + 1);
  localparam int unsigned PH_W    = $clog2(2 * WR_CYCLES);
  localparam int unsigned HDR_LEN = 11;

  // The raster advance ("NEXT") is folded into the COMPARE/SEND exit edge,
  // so it shares its cycle with the following LOOKUP.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [XW-1:0]    x_n;
  logic [YW-1:0]    y_n;
  logic             busy_n, frame_done_n, dcx_n, wr_n;
  logic [7:0]       d_n;
  logic             valid, valid_n;
  logic             force_q, force_n;
  logic [2:0]       code_q, code_n;
  logic [3:0]       hdr, hdr_n;
  logic             in_pix, in_pix_n;
  logic [PW-1:0]    pix, pix_n;
  logic             lo, lo_n;
  logic [PH_W-1:0]  ph, ph_n;

  logic [2:0]       shadow [CELLS];
  logic [IDX_W-1:0] idx;
  logic             shadow_we;
  logic [15:0]      xs, xe, ys, ye, color;
  logic             last_cell, last_byte, adv, load_byte;

  assign idx = IDX_W'(32'(y) * GRID_W + 32'(x));
  assign xs  = 16'(X_OFFSET + 32'(x) * CELL_PX);
  assign xe  = 16'(X_OFFSET + 32'(x) * CELL_PX + CELL_PX - 1);
  assign ys  = 16'(Y_OFFSET + 32'(y) * CELL_PX);
  assign ye  = 16'(Y_OFFSET + 32'(y) * CELL_PX + CELL_PX - 1);

  assign last_cell = (x == XW'(GRID_W - 1)) && (y == YW'(GRID_H - 1));
  assign last_byte = in_pix && lo && (pix == PW'(NPIX - 1));

  // Object code to RGB565 colour
  always_comb begin
    case (code_q)
      3'd0:    color = 16'h0000;
      3'd1:    color = 16'h07E0;
      3'd2:    color = 16'hFFE0;
      3'd3:    color = 16'hF800;
      3'd4:    color = 16'hFFFF;
      default: color = 16'h001F;
    endcase
  end

  // {dcx, byte} for a position in the cell sequence: 11 window bytes, then pixels hi/lo
  function automatic logic [8:0] cell_byte(input logic [3:0]  h,
                                           input logic        p,
                                           input logic        l,
                                           input logic [15:0] xs_i,
                                           input logic [15:0] xe_i,
                                           input logic [15:0] ys_i,
                                           input logic [15:0] ye_i,
                                           input logic [15:0] col);
    logic [8:0] b;
    b = {1'b1, (l ? col[7:0] : col[15:8])};
    if (!p) begin
      case (h)
        4'd0:    b = {1'b0, 8'h2A};
        4'd1:    b = {1'b1, xs_i[15:8]};
        4'd2:    b = {1'b1, xs_i[7:0]};
        4'd3:    b = {1'b1, xe_i[15:8]};
        4'd4:    b = {1'b1, xe_i[7:0]};
        4'd5:    b = {1'b0, 8'h2B};
        4'd6:    b = {1'b1, ys_i[15:8]};
        4'd7:    b = {1'b1, ys_i[7:0]};
        4'd8:    b = {1'b1, ye_i[15:8]};
        4'd9:    b = {1'b1, ye_i[7:0]};
        default: b = {1'b0, 8'h2C};
      endcase
    end
    return b;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    x_n          = x;
    y_n          = y;
    busy_n       = busy;
    frame_done_n = 1'b0;
    dcx_n        = dcx;
    wr_n         = wr;
    d_n          = D;
    valid_n      = valid;
    force_n      = force_q;
    code_n       = code_q;
    hdr_n        = hdr;
    in_pix_n     = in_pix;
    pix_n        = pix;
    lo_n         = lo;
    ph_n         = ph;
    shadow_we    = 1'b0;
    adv          = 1'b0;
    load_byte    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOOKUP;
          force_n = full_redraw | ~valid;
          x_n     = '0;
          y_n     = '0;
          busy_n  = 1'b1;
        end
      end
      S_LOOKUP: state_n = S_COMPARE;
      S_COMPARE: begin
        code_n = obj_code;
        if (force_q || (obj_code != shadow[idx])) begin
          state_n   = S_SEND;
          hdr_n     = '0;
          in_pix_n  = 1'b0;
          pix_n     = '0;
          lo_n      = 1'b0;
          ph_n      = '0;
          load_byte = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      S_SEND: begin
        if (ph == PH_W'(2 * WR_CYCLES - 1)) begin
          if (last_byte) begin
            shadow_we = 1'b1;
            adv       = 1'b1;
          end else begin
            ph_n      = '0;
            load_byte = 1'b1;
            if (!in_pix) begin
              if (hdr == 4'(HDR_LEN - 1)) in_pix_n = 1'b1;
              else                         hdr_n    = hdr + 4'd1;
            end else begin
              lo_n = ~lo;
              if (lo) pix_n = pix + PW'(1);
            end
          end
        end else begin
          ph_n = ph + PH_W'(1);
          if (ph == PH_W'(WR_CYCLES - 1)) wr_n = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        valid_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      if (last_cell) begin
        state_n      = S_DONE;
        frame_done_n = 1'b1;
      end else begin
        state_n = S_LOOKUP;
        if (x == XW'(GRID_W - 1)) begin
          x_n = '0;
          y_n = y + YW'(1);
        end else begin
          x_n = x + XW'(1);
        end
      end
    end

    // A new byte is presented on the same cycle wr falls
    if (load_byte) begin
      wr_n           = 1'b0;
      {dcx_n, d_n}   = cell_byte(hdr_n, in_pix_n, lo_n, xs, xe, ys, ye, color);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dcx        <= 1'b1;
      wr         <= 1'b1;
      D          <= 8'h00;
      valid      <= 1'b0;
      force_q    <= 1'b0;
      code_q     <= '0;
      hdr        <= '0;
      in_pix     <= 1'b0;
      pix        <= '0;
      lo         <= 1'b0;
      ph         <= '0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      dcx        <= dcx_n;
      wr         <= wr_n;
      D          <= d_n;
      valid      <= valid_n;
      force_q    <= force_n;
      code_q     <= code_n;
      hdr        <= hdr_n;
      in_pix     <= in_pix_n;
      pix        <= pix_n;
      lo         <= lo_n;
      ph         <= ph_n;
    end
  end

  // Shadow keeps its contents through reset; the valid flag decides whether it is trusted
  always_ff @(posedge clk) begin
    if (nrst && shadow_we) shadow[idx] <= code_q;
  end

endmodule

// File: tb/tb_grid_frame_renderer.sv
// Scoreboard bench for grid_frame_renderer: a frame model predicts every LCD byte and
// a bus monitor checks strobe timing and pops the prediction on each wr rising edge.
module tb_grid_frame_renderer;

  localparam int GW     = 8;
  localparam int GH     = 6;
  localparam int CP     = 2;
  localparam int XO     = 250;
  localparam int YO     = 3;
  localparam int WR     = 3;
  localparam int CELLS  = GW * GH;
  localparam int NB     = 11 + 2 * CP * CP;
  localparam int LIMIT  = 20000;
  localparam int P_KEEP = 0, P_SET32 = 1, P_MULTI = 2, P_CLR32 = 3;

  typedef struct packed {
    logic       dcx;
    logic [7:0] d;
    logic       first;
  } bus_t;

  typedef struct {
    bit    fr;
    int    pat;
    int    exp_cells;
    string name;
  } vec_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       full_redraw = 1'b0;
  logic [2:0] obj_code;
  logic [2:0] x, y;
  logic       busy, frame_done, dcx, wr;
  logic [7:0] D;

  logic [2:0] codes [CELLS];
  logic [2:0] msh [CELLS];
  bit         mvalid;
  bus_t       exp_q[$];
  logic [8:0] seen[$];
  logic [8:0] hdr_exp [11];
  vec_t       vecs [7];

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_rise = 0;
  bit   mon_en = 1'b0;
  logic wr_prev = 1'b1;
  logic [8:0] cur = '0;
  int   lo_cnt = 0;
  int   hi_cnt = 100;
  bus_t e_pop;

  grid_frame_renderer #(
    .GRID_W(GW), .GRID_H(GH), .CELL_PX(CP),
    .X_OFFSET(XO), .Y_OFFSET(YO), .WR_CYCLES(WR)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .full_redraw(full_redraw),
    .obj_code(obj_code), .x(x), .y(y), .busy(busy), .frame_done(frame_done),
    .dcx(dcx), .wr(wr), .D(D)
  );

  always #5 clk = ~clk;

  assign obj_code = codes[int'(y) * GW + int'(x)];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Bus monitor: strobe widths, byte stability, and scoreboard pop on wr rise
  always @(negedge clk) begin
    if (!mon_en) begin
      wr_prev = 1'b1;
      lo_cnt  = 0;
      hi_cnt  = 100;
    end else begin
      if (!wr && wr_prev) begin
        if (exp_q.size() > 0 && !exp_q[0].first) check("wr_high_clocks", hi_cnt, WR);
        cur    = {dcx, D};
        lo_cnt = 1;
        hi_cnt = 0;
      end else if (!wr) begin
        lo_cnt++;
        check("bus_stable_low", int'({dcx, D}), int'(cur));
      end else if (!wr_prev) begin
        check("wr_low_clocks", lo_cnt, WR);
        check("bus_stable_rise", int'({dcx, D}), int'(cur));
        n_rise++;
        seen.push_back({dcx, D});
        hi_cnt = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 1, 0);
        end else begin
          e_pop = exp_q.pop_front();
          check("bus_byte", int'({dcx, D}), int'({e_pop.dcx, e_pop.d}));
        end
      end else begin
        hi_cnt++;
        if (hi_cnt <= WR) check("bus_stable_high", int'({dcx, D}), int'(cur));
      end
      wr_prev = wr;
    end
  end

  function automatic logic [15:0] palette(input logic [2:0] c);
    case (c)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h07E0;
      3'd2:    return 16'hFFE0;
      3'd3:    return 16'hF800;
      3'd4:    return 16'hFFFF;
      default: return 16'h001F;
    endcase
  endfunction

  task automatic push(input logic dv, input logic [7:0] dd, input logic f);
    bus_t b;
    b.dcx = dv; b.d = dd; b.first = f;
    exp_q.push_back(b);
  endtask

  task automatic model_cell(input int cx, input int cy, input logic [2:0] c);
    logic [15:0] xs, xe, ys, ye, col;
    xs  = 16'(XO + cx * CP);
    xe  = 16'(XO + cx * CP + CP - 1);
    ys  = 16'(YO + cy * CP);
    ye  = 16'(YO + cy * CP + CP - 1);
    col = palette(c);
    push(1'b0, 8'h2A, 1'b1);
    push(1'b1, xs[15:8], 1'b0); push(1'b1, xs[7:0], 1'b0);
    push(1'b1, xe[15:8], 1'b0); push(1'b1, xe[7:0], 1'b0);
    push(1'b0, 8'h2B, 1'b0);
    push(1'b1, ys[15:8], 1'b0); push(1'b1, ys[7:0], 1'b0);
    push(1'b1, ye[15:8], 1'b0); push(1'b1, ye[7:0], 1'b0);
    push(1'b0, 8'h2C, 1'b0);
    for (int i = 0; i < CP * CP; i++) begin
      push(1'b1, col[15:8], 1'b0);
      push(1'b1, col[7:0], 1'b0);
    end
  endtask

  task automatic apply_pattern(input int p);
    case (p)
      P_SET32: codes[2 * GW + 3] = 3'd1;
      P_CLR32: codes[2 * GW + 3] = 3'd0;
      P_MULTI: begin
        codes[0]          = 3'd4;
        codes[5 * GW + 7] = 3'd3;
        codes[1 * GW + 4] = 3'd2;
        codes[1 * GW + 5] = 3'd7;
      end
      default: ;
    endcase
  endtask

  task automatic reset_checks(input string name);
    check({name, "_wr"}, int'(wr), 1);
    check({name, "_dcx"}, int'(dcx), 1);
    check({name, "_D"}, int'(D), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_frame_done"}, int'(frame_done), 0);
    check({name, "_x"}, int'(x), 0);
    check({name, "_y"}, int'(y), 0);
  endtask

  // Predict the frame, launch it, and check timing plus byte totals; called at posedge+1
  task automatic run_frame(input bit fr, input int exp_cells, input string name, input int poke);
    bit force_all;
    int cyc, r0, exp_cyc;
    force_all = fr || !mvalid;
    for (int cy = 0; cy < GH; cy++)
      for (int cx = 0; cx < GW; cx++)
        if (force_all || codes[cy * GW + cx] != msh[cy * GW + cx]) begin
          model_cell(cx, cy, codes[cy * GW + cx]);
          msh[cy * GW + cx] = codes[cy * GW + cx];
        end
    mvalid = 1'b1;
    r0 = n_rise;
    start = 1'b1; full_redraw = fr;
    @(posedge clk); #1;
    start = 1'b0; full_redraw = 1'b0;
    cyc = 1;
    check({name, "_busy_start"}, int'(busy), 1);
    while (!frame_done && cyc < LIMIT) begin
      if (poke != 0 && cyc == poke) begin start = 1'b1; full_redraw = 1'b1; end
      else begin start = 1'b0; full_redraw = 1'b0; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; full_redraw = 1'b0;
    exp_cyc = 2 * (CELLS - exp_cells) + exp_cells * (2 + NB * 2 * WR) + 1;
    check({name, "_done_cycle"}, cyc, exp_cyc);
    check({name, "_busy_at_done"}, int'(busy), 1);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, int'(frame_done), 0);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_bytes"}, n_rise - r0, exp_cells * NB);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_single();
    check("single_len", seen.size(), NB);
    for (int i = 0; i < 11; i++)
      if (i < seen.size()) check("single_hdr", int'(seen[i]), int'(hdr_exp[i]));
    for (int j = 0; j < CP * CP; j++)
      if (12 + 2 * j < seen.size()) begin
        check("single_pix_hi", int'(seen[11 + 2 * j]), 'h107);
        check("single_pix_lo", int'(seen[12 + 2 * j]), 'h1E0);
      end
  endtask

  initial begin
    int extra;
    for (int i = 0; i < CELLS; i++) begin
      codes[i] = 3'd0;
      msh[i]   = 3'd0;
    end
    mvalid  = 1'b0;
    hdr_exp = '{9'h02A, 9'h101, 9'h100, 9'h101, 9'h101, 9'h02B,
                9'h100, 9'h107, 9'h100, 9'h108, 9'h02C};
    vecs[0] = '{1'b0, P_KEEP,  CELLS, "first"};
    vecs[1] = '{1'b0, P_KEEP,  0,     "clean"};
    vecs[2] = '{1'b0, P_SET32, 1,     "single"};
    vecs[3] = '{1'b0, P_MULTI, 4,     "multi"};
    vecs[4] = '{1'b1, P_KEEP,  CELLS, "full_redraw"};
    vecs[5] = '{1'b0, P_KEEP,  0,     "after_full"};
    vecs[6] = '{1'b0, P_CLR32, 1,     "revert"};

    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    nrst   = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      apply_pattern(vecs[i].pat);
      seen.delete();
      run_frame(vecs[i].fr, vecs[i].exp_cells, vecs[i].name, 0);
      if (i == 2) check_single();
    end

    // start and full_redraw pulsed while busy must be ignored
    codes[1 * GW + 1] = 3'd5;
    run_frame(1'b0, 1, "busy_start", 10);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (frame_done || busy) extra++;
    end
    check("no_second_frame", extra, 0);
    run_frame(1'b0, 0, "after_poke", 0);

    // Reset in the middle of a cell transfer
    mon_en = 1'b0;
    start = 1'b1; full_redraw = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; full_redraw = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_in_send_busy", int'(busy), 1);
    nrst = 1'b0;
    @(posedge clk); #1;
    reset_checks("mid_send");
    nrst   = 1'b1;
    exp_q.delete();
    mvalid = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, CELLS, "post_reset", 0);
    run_frame(1'b0, 0, "post_reset_clean", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
